branch_ctrl: RTL and testbench

BRANCH_CTRL -- requirements
Module: branch_ctrl

---
 rtl/branch_pkg.sv | 22 ++
 rtl/target_lut.sv | 32 +++
 rtl/branch_ctrl.sv | 109 ++++++++++
 tb/tb_branch_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared decode constants and enums for the branch controller slice.
package branch_pkg;

    localparam logic [2:0] BR_OPCODE = 3'b111;
    localparam int         LUT_DEPTH = 16;
    localparam int         LUT_IDX_W = 4;

    typedef enum logic [1:0] {
        BR_EZ     = 2'b00,
        BR_NZ     = 2'b01,
        BR_ALWAYS = 2'b10,
        BR_HALT   = 2'b11
    } br_type_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_FLUSH = 2'b10,
        S_HALT  = 2'b11
    } state_e;

endpackage

// File: rtl/target_lut.sv
// 16-entry jump-target table: one synchronous write port, one asynchronous read port.
module target_lut
    import branch_pkg::*;
#(
    parameter int W = 8
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 we,
    input  logic [LUT_IDX_W-1:0] wr_idx,
    input  logic [W-1:0]         wr_data,
    input  logic [LUT_IDX_W-1:0] rd_idx,
    output logic [W-1:0]         rd_data
);

    logic [W-1:0] mem [LUT_DEPTH];

    // NOTE: the table is cleared by reset, so it must be built from flops rather than a RAM macro.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Read sees the pre-edge contents; a same-cycle write is not bypassed.
    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/branch_ctrl.sv
// Branch controller: decodes branch/HALT instructions, drives fetch controls and counts taken branches.
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int T = 10,
    parameter int W = 8,
    parameter int I = 9
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic [I-1:0] Instr,
    input  logic         ZeroIn,
    input  logic         FlagWe,
    input  logic         LutWe,
    input  logic [3:0]   LutIdx,
    input  logic [W-1:0] LutData,
    output logic         BranchEZ,
    output logic         BranchNZ,
    output logic         BranchAlways,
    output logic         Zero,
    output logic [W-1:0] Target,
    output logic         done,
    output logic         Flush,
    output logic [15:0]  BranchCount
);

    state_e      state_q, state_d;
    br_type_e    br_type;
    logic        is_branch;
    logic        in_run;
    logic        taken;
    logic        halt_hit;
    logic        zero_q;
    logic [15:0] branch_count_q;

    assign is_branch = (Instr[8:6] == BR_OPCODE);
    assign br_type   = br_type_e'(Instr[5:4]);
    assign in_run    = (state_q == S_RUN);

    // The flag used here is the registered one, so a same-cycle FlagWe does not affect the decision.
    assign taken = in_run && is_branch &&
                   ((br_type == BR_ALWAYS) ||
                    (br_type == BR_EZ &&  zero_q) ||
                    (br_type == BR_NZ && !zero_q));
    assign halt_hit = in_run && is_branch && (br_type == BR_HALT);

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d is defaulted first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (Start) state_d = S_RUN;
            S_RUN: begin
                if (taken)         state_d = S_FLUSH;
                else if (halt_hit) state_d = S_HALT;
            end
            S_FLUSH: state_d = S_RUN;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        BranchEZ     = taken && (br_type == BR_EZ);
        BranchNZ     = taken && (br_type == BR_NZ);
        BranchAlways = taken && (br_type == BR_ALWAYS);
        done         = (state_q == S_IDLE) || (state_q == S_HALT);
        Flush        = (state_q == S_FLUSH);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            zero_q <= 1'b0;
        end else if (FlagWe) begin
            zero_q <= ZeroIn;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            branch_count_q <= '0;
        end else if (taken && (branch_count_q != 16'hFFFF)) begin
            branch_count_q <= branch_count_q + 16'd1;
        end
    end

    target_lut #(.W(W)) u_lut (
        .Clk     (Clk),
        .Reset   (Reset),
        .we      (LutWe),
        .wr_idx  (LutIdx),
        .wr_data (LutData),
        .rd_idx  (Instr[3:0]),
        .rd_data (Target)
    );

    assign Zero        = zero_q;
    assign BranchCount = branch_count_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_branch_ctrl;
    localparam int T = 10;
    localparam int W = 8;
    localparam int I = 9;

    localparam int MODE_IDLE  = 0;
    localparam int MODE_RUN   = 1;
    localparam int MODE_FLUSH = 2;
    localparam int MODE_HALT  = 3;

    logic         Clk = 1'b0, Reset = 1'b1, Start = 1'b0;
    logic [I-1:0] Instr = '0;
    logic         ZeroIn = 1'b0, FlagWe = 1'b0, LutWe = 1'b0;
    logic [3:0]   LutIdx = '0;
    logic [W-1:0] LutData = '0;
    logic         BranchEZ, BranchNZ, BranchAlways, Zero, done, Flush;
    logic [W-1:0] Target;
    logic [15:0]  BranchCount;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model
    int           m_mode;
    bit           m_zero;
    logic [W-1:0] m_lut [16];
    int           m_cnt;

    branch_ctrl #(.T(T), .W(W), .I(I)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Instr(Instr), .ZeroIn(ZeroIn),
        .FlagWe(FlagWe), .LutWe(LutWe), .LutIdx(LutIdx), .LutData(LutData),
        .BranchEZ(BranchEZ), .BranchNZ(BranchNZ), .BranchAlways(BranchAlways),
        .Zero(Zero), .Target(Target), .done(done), .Flush(Flush), .BranchCount(BranchCount)
    );

    always #5 Clk = ~Clk;

    function automatic logic [I-1:0] mk(input int kind, input int idx);
        logic [I-1:0] v;
        v = '0;
        v[8:6] = 3'b111;
        v[5:4] = kind[1:0];
        v[3:0] = idx[3:0];
        return v;
    endfunction

    // {EZ, NZ, BA} the model expects for the current instruction
    function automatic logic [2:0] exp_br(input logic [I-1:0] ins);
        if (m_mode != MODE_RUN || ins[8:6] != 3'b111) return 3'b000;
        case (ins[5:4])
            2'd0:    return m_zero  ? 3'b100 : 3'b000;
            2'd1:    return !m_zero ? 3'b010 : 3'b000;
            2'd2:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] obs_br();
        return {BranchEZ, BranchNZ, BranchAlways};
    endfunction

    task automatic model_reset();
        m_mode = MODE_IDLE;
        m_zero = 1'b0;
        m_cnt  = 0;
        for (int i = 0; i < 16; i++) m_lut[i] = '0;
    endtask

    // Advance one clock edge, update the model, return at the following negedge + 1.
    task automatic tick();
        logic [2:0] eb;
        bit         halt_now;
        eb       = exp_br(Instr);
        halt_now = (m_mode == MODE_RUN) && (Instr[8:6] == 3'b111) && (Instr[5:4] == 2'b11);
        @(posedge Clk);
        if (eb != 3'b000 && m_cnt < 65535) m_cnt++;
        if (FlagWe) m_zero = ZeroIn;
        if (LutWe)  m_lut[LutIdx] = LutData;
        case (m_mode)
            MODE_IDLE:  if (Start) m_mode = MODE_RUN;
            MODE_RUN:   if (eb != 3'b000) m_mode = MODE_FLUSH; else if (halt_now) m_mode = MODE_HALT;
            MODE_FLUSH: m_mode = MODE_RUN;
            default:    m_mode = MODE_HALT;
        endcase
        @(negedge Clk);
        #1;
    endtask

    task automatic test_reset();
        #2 Reset = 1'b0;
        #1;
        model_reset();
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL reset_done got %b exp 1", done); end
        n_checks++; if (Flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush got %b exp 0", Flush); end
        n_checks++; if (BranchCount !== 16'h0) begin n_fail++; $display("FAIL reset_count got %h exp 0", BranchCount); end
        n_checks++; if (Zero !== 1'b0) begin n_fail++; $display("FAIL reset_zero got %b exp 0", Zero); end
        n_checks++; if (obs_br() !== 3'b000) begin n_fail++; $display("FAIL reset_branch got %b exp 000", obs_br()); end
        n_checks++; if (Target !== '0) begin n_fail++; $display("FAIL reset_target got %h exp 00", Target); end
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            Instr = mk(2, k);
            tick();
            n_checks++; if (done !== 1'b1 || obs_br() !== 3'b000) begin
                n_fail++; $display("FAIL idle_hold done=%b br=%b exp done=1 br=000", done, obs_br());
            end
        end
    endtask

    task automatic test_start();
        Instr = '0;
        Start = 1'b1;
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL pre_start_done got %b exp 1", done); end
        tick();
        Start = 1'b0;
        n_checks++; if (done !== 1'b0 || Flush !== 1'b0) begin
            n_fail++; $display("FAIL start_run done=%b flush=%b exp 0 0", done, Flush);
        end
    endtask

    task automatic test_lut_ba();
        Instr = 9'h003;
        LutWe = 1'b1; LutIdx = 4'd3; LutData = 8'h2A;
        #1;
        n_checks++; if (Target !== 8'h00) begin n_fail++; $display("FAIL lut_no_bypass got %h exp 00", Target); end
        tick();
        LutWe = 1'b0;
        #1;
        n_checks++; if (Target !== 8'h2A) begin n_fail++; $display("FAIL lut_write got %h exp 2a", Target); end
        Instr = mk(2, 3);
        #1;
        n_checks++; if (obs_br() !== 3'b001 || Target !== 8'h2A) begin
            n_fail++; $display("FAIL ba_taken br=%b tgt=%h exp 001 2a", obs_br(), Target);
        end
        tick();
        n_checks++; if (Flush !== 1'b1 || obs_br() !== 3'b000 || done !== 1'b0) begin
            n_fail++; $display("FAIL ba_flush flush=%b br=%b done=%b exp 1 000 0", Flush, obs_br(), done);
        end
        n_checks++; if (BranchCount !== 16'd1) begin n_fail++; $display("FAIL ba_count got %0d exp 1", BranchCount); end
        Instr = mk(3, 0);
        #1;
        n_checks++; if (obs_br() !== 3'b000) begin n_fail++; $display("FAIL flush_ignores got %b exp 000", obs_br()); end
        tick();
        Instr = '0;
        #1;
        n_checks++; if (Flush !== 1'b0 || done !== 1'b0 || BranchCount !== 16'd1) begin
            n_fail++; $display("FAIL flush_to_run flush=%b done=%b cnt=%0d exp 0 0 1", Flush, done, BranchCount);
        end
    endtask

    task automatic test_cond();
        for (int f = 1; f >= 0; f--) begin
            FlagWe = 1'b1; ZeroIn = f[0]; Instr = '0;
            tick();
            FlagWe = 1'b0;
            n_checks++; if (Zero !== f[0]) begin n_fail++; $display("FAIL flag_load got %b exp %b", Zero, f[0]); end
            for (int ty = 0; ty < 2; ty++) begin
                Instr = mk(ty, ty + 5);
                #1;
                n_checks++; if (obs_br() !== exp_br(Instr)) begin
                    n_fail++; $display("FAIL cond_br flag=%0d type=%0d got %b exp %b", f, ty, obs_br(), exp_br(Instr));
                end
                tick();
                n_checks++; if (Flush !== (m_mode == MODE_FLUSH)) begin
                    n_fail++; $display("FAIL cond_flush flag=%0d type=%0d got %b", f, ty, Flush);
                end
                Instr = '0;
                if (m_mode == MODE_FLUSH) tick();
            end
        end
    endtask

    task automatic test_flag_same_cycle();
        FlagWe = 1'b1; ZeroIn = 1'b1; Instr = mk(0, 1);
        #1;
        n_checks++; if (obs_br() !== 3'b000) begin n_fail++; $display("FAIL old_flag_br got %b exp 000", obs_br()); end
        tick();
        FlagWe = 1'b0; Instr = '0;
        #1;
        n_checks++; if (Zero !== 1'b1 || Flush !== 1'b0) begin
            n_fail++; $display("FAIL old_flag_next zero=%b flush=%b exp 1 0", Zero, Flush);
        end
    endtask

    task automatic test_halt();
        int c0;
        c0 = m_cnt;
        Instr = mk(3, 0);
        tick();
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL halt_done got %b exp 1", done); end
        Instr = mk(2, 3);
        for (int k = 0; k < 3; k++) begin
            Start = k[0];
            #1;
            n_checks++; if (obs_br() !== 3'b000 || done !== 1'b1) begin
                n_fail++; $display("FAIL halt_sticky br=%b done=%b exp 000 1", obs_br(), done);
            end
            tick();
        end
        Start = 1'b0;
        n_checks++; if (BranchCount !== c0[15:0]) begin n_fail++; $display("FAIL halt_count got %0d exp %0d", BranchCount, c0); end
        #2 Reset = 1'b0;
        #1;
        model_reset();
        n_checks++; if (done !== 1'b1 || BranchCount !== 16'h0 || Zero !== 1'b0 || Target !== '0) begin
            n_fail++; $display("FAIL async_reset done=%b cnt=%h zero=%b tgt=%h", done, BranchCount, Zero, Target);
        end
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        tick();
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL post_reset_idle got %b exp 1", done); end
    endtask

    task automatic test_saturation();
        force dut.branch_count_q = 16'hFFFD;
        @(negedge Clk);
        release dut.branch_count_q;
        m_cnt = 16'hFFFD;
        #1;
        Start = 1'b1; Instr = '0;
        tick();
        Start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            Instr = mk(2, k);
            tick();
            n_checks++; if (BranchCount !== m_cnt[15:0]) begin
                n_fail++; $display("FAIL saturate step %0d got %h exp %h", k, BranchCount, m_cnt[15:0]);
            end
            Instr = '0;
            tick();
        end
        n_checks++; if (BranchCount !== 16'hFFFF) begin n_fail++; $display("FAIL saturate_final got %h exp ffff", BranchCount); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 800; k++) begin
            Start   = ($urandom_range(0, 3) == 0);
            Instr   = I'($urandom);
            if ($urandom_range(0, 2) != 0) Instr[8:6] = 3'b111;
            if (Instr[5:4] == 2'b11 && $urandom_range(0, 7) != 0) Instr[5:4] = 2'($urandom_range(0, 2));
            FlagWe  = ($urandom_range(0, 2) == 0);
            ZeroIn  = 1'($urandom);
            LutWe   = ($urandom_range(0, 1) == 0);
            LutIdx  = 4'($urandom);
            LutData = W'($urandom);
            #1;
            n_checks++;
            if (obs_br() !== exp_br(Instr) || Target !== m_lut[Instr[3:0]] ||
                done !== (m_mode == MODE_IDLE || m_mode == MODE_HALT) ||
                Flush !== (m_mode == MODE_FLUSH) || Zero !== m_zero || BranchCount !== m_cnt[15:0]) begin
                n_fail++;
                $display("FAIL random cyc %0d br=%b/%b tgt=%h/%h done=%b flush=%b zero=%b/%b cnt=%0d/%0d mode=%0d",
                         k, obs_br(), exp_br(Instr), Target, m_lut[Instr[3:0]], done, Flush, Zero, m_zero,
                         BranchCount, m_cnt, m_mode);
            end
            if ($urandom_range(0, 49) == 0 || (m_mode == MODE_HALT && $urandom_range(0, 3) == 0)) begin
                Reset = 1'b0;
                #1;
                model_reset();
                n_checks++; if (done !== 1'b1 || Flush !== 1'b0 || BranchCount !== 16'h0 || obs_br() !== 3'b000) begin
                    n_fail++; $display("FAIL random_reset done=%b flush=%b cnt=%h br=%b", done, Flush, BranchCount, obs_br());
                end
                @(negedge Clk);
                Reset = 1'b1;
                #1;
            end else begin
                tick();
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_start();
        test_lut_ba();
        test_cond();
        test_flag_same_cycle();
        test_halt();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
